dmem_trace_mon: RTL and testbench
=================================

// Module: dmem_trace_mon
// PURPOSE
//  Synthesizable, parametrised data-bus trace monitor for the single-cycle mipse core.
//  Snoops the dmem write port: cycle counter, halt-on-write detection, NWATCH address
//  watchpoints with last-value capture, and a LOG_DEPTH-deep write log drained by valid/ready.
//  Replaces ad-hoc bench $display polling of dmem words; usable in sim and on FPGA.
// PARAMETERS
//  DATA_W     32            bus/data width
//  NWATCH     4             number of watchpoint channels (1..8)
//  LOG_DEPTH  16            write-log entries, power of 2 (>=2)
//  CNT_W      32            cycle counter width
//  HALT_ADDR  32'h00000050  byte address whose store halts the monitor
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous reset, active low
//  pc           in   DATA_W         core PC (instruction of current cycle)
//  daddr        in   DATA_W         dmem byte address (core aluresult)
//  wdata        in   DATA_W         dmem write data
//  we           in   1              dmem write enable (core memwrite)
//  watch_addr   in   NWATCH*DATA_W  watch byte addresses, channel i at [i*DATA_W +: DATA_W]
//  watch_en     in   NWATCH         per-channel enable
//  hit          out  NWATCH         one-cycle pulse per channel, 1 clk after matching write
//  watch_val    out  NWATCH*DATA_W  last data written to each watched word
//  log_valid    out  1              log head entry available
//  log_ready    in   1              consumer accepts head entry
//  log_pc       out  DATA_W         head entry: pc of the store
//  log_addr     out  DATA_W         head entry: daddr of the store
//  log_data     out  DATA_W         head entry: wdata of the store
//  log_overflow out  1              sticky: a log push was dropped
//  log_clr      in   1              synchronous flush of log + overflow
//  halted       out  1              halt store seen
//  cycle_count  out  CNT_W          cycles since reset release
//  halt_cycle   out  CNT_W          cycle_count value at the halt store
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output and register 0; FSM RUN; FIFO empty. Reset
//    mid-operation discards log contents, counters, watch values and halt state.
//  - FSM: RUN -> HALT on (we && daddr==HALT_ADDR); HALT is terminal until rst_n.
//  - RUN: cycle_count += 1 per clk, saturating at all-ones. HALT: frozen.
//  - Halt store: halted<=1, halt_cycle<=cycle_count (pre-increment value), same edge.
//  - Match: ch i matches when state==RUN && we && watch_en[i] &&
//    daddr[DATA_W-1:2]==watch_addr_i[DATA_W-1:2] (word compare; byte bits ignored).
//    On match: watch_val_i<=wdata and hit[i]=1 for exactly the next cycle. Several
//    channels may match one store; each updates.
//  - Log push: once per cycle when any channel matches; entry {pc,daddr,wdata}.
//    The halt store is processed (watch+log) in the cycle it halts; later stores are not.
//  - Log pop: log_valid && log_ready, same edge. No fall-through: push into empty
//    FIFO raises log_valid the next cycle. log_* outputs 0 when empty.
//  - Full: push with no pop dropped, log_overflow<=1 (sticky). Full + push + pop:
//    both performed, no overflow. Empty + pop request: ignored.
//  - log_clr: empties FIFO, clears log_overflow; wins over push/pop in the same cycle.
//  - Pointers log2(LOG_DEPTH)+1 bits, wrap naturally; full = MSB differ, rest equal.
//  - hit/watch_val/halt/counter are unaffected by log_clr and log state.
// STRUCTURE
//  - def.h gains: `MON_RUN/`MON_HALT state encodings, `MON_HALT_ADDR default; reuses
//    `DATA_W, `ENABLE_N/`DISABLE_N.
//  - One sub-module: trace_fifo (sync FIFO, params WIDTH=3*DATA_W, DEPTH; ports clk,
//    rst_n, clr, push, din, pop, dout, valid, full). Top holds FSM, counter, watch logic.
// TESTING
//  1 Reset: hold rst_n=0 2 clks with we=1 at HALT_ADDR -> all outputs 0; release, 5 clks
//    idle -> cycle_count=5, halted=0, log_valid=0.
//  2 Watch: watch_addr0=0x120, en=1; store 0xDEADBEEF to 0x122 -> next clk hit[0]=1
//    for one cycle, watch_val0=0xDEADBEEF, log entry {pc,0x122,0xDEADBEEF}.
//  3 Multi-channel: ch0,ch1 both 0x200; one store -> hit=2'b11, exactly one log push.
//  4 Overflow: log_ready=0, 17 matching stores (LOG_DEPTH=16) -> 16 entries,
//    log_overflow=1; drain in order matches first 16; log_clr -> valid=0, overflow=0.
//  5 Full + push + pop same cycle -> count stays 16, overflow stays 0, new entry last.
//  6 Halt: store to 0x50 at cycle 40 (watched) -> halted=1, halt_cycle=40, entry
//    logged; later watched stores: no hit, no push; cycle_count frozen at 41.

Source files
------------

// File: rtl/dmem_trace_mon_pkg.sv
// -----------------------------------------------------------------------------
// dmem_trace_mon_pkg
//   Shared types and defaults for the dmem trace monitor.
//   - mon_state_e   : monitor FSM states (RUN counts and snoops, HALT is terminal)
//   - MON_DATA_W    : default bus width of the mipse core
//   - MON_HALT_ADDR : default byte address whose store halts the monitor
//   - ENABLE_N /
//     DISABLE_N     : active-low enable levels (rst_n asserted / released)
// -----------------------------------------------------------------------------
package dmem_trace_mon_pkg;

  typedef enum logic {
    MON_RUN  = 1'b0,
    MON_HALT = 1'b1
  } mon_state_e;

  localparam int unsigned MON_DATA_W    = 32;
  localparam logic [31:0] MON_HALT_ADDR = 32'h0000_0050;

  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

endpackage

// File: rtl/dmem_trace_mon_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
//   Synchronous FIFO holding the write-log entries of the trace monitor.
//   Ports:
//     clk   in  rising-edge clock
//     rst_n in  asynchronous reset, active low (empties the FIFO)
//     clr   in  synchronous flush; has priority over push/pop
//     push  in  write din (dropped when full unless a pop happens too)
//     din   in  entry to write
//     pop   in  consume head entry (ignored when empty)
//     dout  out head entry, all zeros when empty
//     valid out FIFO not empty
//     full  out FIFO holds DEPTH entries
//   No fall-through: a push into an empty FIFO shows up on dout one cycle later.
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; stale contents are never visible because dout is
  // masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign valid = !empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dmem_trace_mon.sv
// -----------------------------------------------------------------------------
// dmem_trace_mon
//   Data-bus trace monitor for the single-cycle mipse core. Snoops the dmem
//   write port and provides a cycle counter, halt-on-store detection, NWATCH
//   word watchpoints with last-value capture and a write log drained by
//   valid/ready.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     pc, daddr, wdata, we   snooped core PC and dmem write port
//     watch_addr, watch_en   per-channel watch byte address / enable
//     hit                    one-cycle pulse per channel after a matching store
//     watch_val              last data stored to each watched word
//     log_valid/log_ready    write-log head handshake
//     log_pc/addr/data       write-log head entry (zero when empty)
//     log_overflow           sticky: a log push was dropped
//     log_clr                synchronous flush of log and overflow flag
//     halted, cycle_count,
//     halt_cycle             halt status and cycle bookkeeping
// -----------------------------------------------------------------------------
module dmem_trace_mon
  import dmem_trace_mon_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NWATCH    = 4,
  parameter int                LOG_DEPTH = 16,
  parameter int                CNT_W     = 32,
  parameter logic [DATA_W-1:0] HALT_ADDR = 32'h0000_0050
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        daddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic [NWATCH*DATA_W-1:0] watch_addr,
  input  logic [NWATCH-1:0]        watch_en,
  output logic [NWATCH-1:0]        hit,
  output logic [NWATCH*DATA_W-1:0] watch_val,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [DATA_W-1:0]        log_pc,
  output logic [DATA_W-1:0]        log_addr,
  output logic [DATA_W-1:0]        log_data,
  output logic                     log_overflow,
  input  logic                     log_clr,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         halt_cycle
);

  localparam int LW = 3 * DATA_W;

  mon_state_e               state_q;
  logic [CNT_W-1:0]         cycle_count_q;
  logic [CNT_W-1:0]         halt_cycle_q;
  logic                     halted_q;
  logic [NWATCH-1:0]        match;
  logic [NWATCH-1:0]        hit_q;
  logic [NWATCH*DATA_W-1:0] watch_val_q;
  logic                     overflow_q, overflow_d;
  logic                     run;
  logic                     halt_store;
  logic                     log_push;
  logic                     fifo_full;
  logic                     fifo_valid;
  logic [LW-1:0]            fifo_dout;

  assign run        = (state_q == MON_RUN);
  assign halt_store = run && we && (daddr == HALT_ADDR);

  // Watch channels: word compare, byte-offset bits ignored. Only stores seen
  // while running count, so the halting store itself is still processed.
  for (genvar gi = 0; gi < NWATCH; gi++) begin : g_watch
    assign match[gi] = run && we && watch_en[gi] &&
      (daddr[DATA_W-1:2] == watch_addr[gi*DATA_W+2 +: DATA_W-2]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        watch_val_q[gi*DATA_W +: DATA_W] <= '0;
      end else if (match[gi]) begin
        watch_val_q[gi*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= match;
  end

  // Monitor FSM with counter and halt capture. The halting edge still counts,
  // so cycle_count ends one past halt_cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MON_RUN;
      cycle_count_q <= '0;
      halt_cycle_q  <= '0;
      halted_q      <= 1'b0;
    end else if (state_q == MON_RUN) begin
      if (cycle_count_q != {CNT_W{1'b1}}) cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (halt_store) begin
        state_q      <= MON_HALT;
        halted_q     <= 1'b1;
        halt_cycle_q <= cycle_count_q;
      end
    end
  end

  // One log push per store, however many channels matched.
  assign log_push = |match;

  // A push into a full FIFO is only lost when the consumer is not popping.
  always_comb begin
    overflow_d = overflow_q;
    if (log_clr)                                 overflow_d = 1'b0;
    else if (log_push && fifo_full && !log_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  trace_fifo #(
    .WIDTH (LW),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (log_clr),
    .push  (log_push),
    .din   ({pc, daddr, wdata}),
    .pop   (log_ready),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign hit          = hit_q;
  assign watch_val    = watch_val_q;
  assign log_valid    = fifo_valid;
  assign log_pc       = fifo_dout[3*DATA_W-1:2*DATA_W];
  assign log_addr     = fifo_dout[2*DATA_W-1:DATA_W];
  assign log_data     = fifo_dout[DATA_W-1:0];
  assign log_overflow = overflow_q;
  assign halted       = halted_q;
  assign cycle_count  = cycle_count_q;
  assign halt_cycle   = halt_cycle_q;

endmodule

// File: tb/tb_dmem_trace_mon.sv
module tb_dmem_trace_mon;

  localparam int NW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc, daddr, wdata;
  logic          we;
  logic [NW*32-1:0] watch_addr;
  logic [NW-1:0] watch_en;
  logic [NW-1:0] hit;
  logic [NW*32-1:0] watch_val;
  logic          log_valid, log_ready;
  logic [31:0]   log_pc, log_addr, log_data;
  logic          log_overflow, log_clr, halted;
  logic [31:0]   cycle_count, halt_cycle;

  int n_chk = 0;
  int n_err = 0;

  dmem_trace_mon #(
    .DATA_W(32), .NWATCH(NW), .LOG_DEPTH(DEPTH), .CNT_W(32), .HALT_ADDR(32'h50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .daddr(daddr), .wdata(wdata), .we(we),
    .watch_addr(watch_addr), .watch_en(watch_en), .hit(hit), .watch_val(watch_val),
    .log_valid(log_valid), .log_ready(log_ready), .log_pc(log_pc),
    .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow),
    .log_clr(log_clr), .halted(halted), .cycle_count(cycle_count),
    .halt_cycle(halt_cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        m_log[$];
  logic [31:0] m_wval[NW] = '{default: 32'h0};
  logic [NW-1:0] m_hit = '0;
  logic        m_ovf = 1'b0;
  logic        m_halted = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_halt_cycle = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    logic [NW-1:0] mt;
    logic running;
    ent_t e;
    if (!rst_n) begin
      m_log.delete();
      for (int i = 0; i < NW; i++) m_wval[i] = 32'h0;
      m_hit = '0; m_ovf = 0; m_halted = 0; m_cnt = 0; m_halt_cycle = 0;
    end else begin
      running = !m_halted;
      for (int i = 0; i < NW; i++) begin
        mt[i] = running && we && watch_en[i] &&
                ((daddr >> 2) == (watch_addr[i*32 +: 32] >> 2));
        if (mt[i]) m_wval[i] = wdata;
      end
      m_hit = mt;
      if (log_clr) begin
        m_log.delete();
        m_ovf = 0;
      end else begin
        if (log_ready && m_log.size() > 0) void'(m_log.pop_front());
        if (mt != '0) begin
          if (m_log.size() < DEPTH) begin
            e.pc = pc; e.addr = daddr; e.data = wdata;
            m_log.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (running && we && daddr == 32'h50) begin
        m_halted = 1;
        m_halt_cycle = m_cnt;
      end
      if (running && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("hit", hit, m_hit);
    for (int i = 0; i < NW; i++) chk("watch_val", watch_val[i*32 +: 32], m_wval[i]);
    chk("log_valid", log_valid, m_log.size() > 0);
    chk("log_pc",   log_pc,   m_log.size() > 0 ? m_log[0].pc   : 32'h0);
    chk("log_addr", log_addr, m_log.size() > 0 ? m_log[0].addr : 32'h0);
    chk("log_data", log_data, m_log.size() > 0 ? m_log[0].data : 32'h0);
    chk("log_overflow", log_overflow, m_ovf);
    chk("halted", halted, m_halted);
    chk("cycle_count", cycle_count, m_cnt);
    chk("halt_cycle", halt_cycle, m_halt_cycle);
  end

  // Inputs change 1 time unit after the falling edge, after the compare ran.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    we = 1; pc = p; daddr = a; wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset held with a halt store present
    rst_n = 0; log_ready = 0; log_clr = 0;
    watch_addr = {4{32'h50}}; watch_en = 4'hF;
    set_store(32'h4, 32'h50, 32'h1111_2222);
    tick(); tick();
    chk("rst_halted", halted, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_hit", hit, 0);
    chk("rst_wval", watch_val, 0);
    chk("rst_valid", log_valid, 0);
    rst_n = 1; we = 0; watch_en = 0;
    repeat (5) tick();
    chk("idle_cycle5", cycle_count, 5);
    chk("idle_halted", halted, 0);
    chk("idle_valid", log_valid, 0);
    $display("T1 reset/idle done cycle_count=%0d", cycle_count);

    // Test 2: single watch, byte-offset store
    watch_addr[31:0] = 32'h120; watch_en = 4'b0001;
    set_store(32'h1000, 32'h122, 32'hDEAD_BEEF);
    tick(); we = 0;
    chk("t2_hit", hit, 4'b0001);
    chk("t2_wval", watch_val[31:0], 32'hDEAD_BEEF);
    chk("t2_valid", log_valid, 1);
    chk("t2_pc", log_pc, 32'h1000);
    chk("t2_addr", log_addr, 32'h122);
    chk("t2_data", log_data, 32'hDEAD_BEEF);
    tick();
    chk("t2_hit_pulse", hit, 0);
    log_ready = 1; tick(); log_ready = 0;
    chk("t2_drained", log_valid, 0);
    $display("T2 watch store done");

    // Test 3: two channels, one store
    watch_addr[31:0] = 32'h200; watch_addr[63:32] = 32'h200; watch_en = 4'b0011;
    set_store(32'h1004, 32'h200, 32'h1234_5678);
    tick(); we = 0;
    chk("t3_hit", hit, 4'b0011);
    chk("t3_wval1", watch_val[63:32], 32'h1234_5678);
    log_ready = 1; tick(); log_ready = 0;
    chk("t3_one_push", log_valid, 0);
    $display("T3 multi-channel done");

    // Test 4: overflow with 17 stores
    watch_addr[31:0] = 32'h300; watch_en = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      set_store(32'h400 + 4 * k, 32'h300, 32'hA000 + k);
      tick();
    end
    we = 0; tick();
    chk("t4_overflow", log_overflow, 1);
    for (int k = 0; k < 16; k++) begin
      chk("t4_drain_valid", log_valid, 1);
      chk("t4_drain_data", log_data, 32'hA000 + k);
      log_ready = 1; tick(); log_ready = 0;
    end
    chk("t4_empty", log_valid, 0);
    chk("t4_ovf_sticky", log_overflow, 1);
    set_store(32'h500, 32'h300, 32'hCAFE); tick(); tick(); we = 0;
    log_clr = 1; tick(); log_clr = 0;
    chk("t4_clr_valid", log_valid, 0);
    chk("t4_clr_ovf", log_overflow, 0);
    $display("T4 overflow/clr done");

    // Test 5: full + push + pop in the same cycle
    for (int k = 0; k < 16; k++) begin
      set_store(32'h600 + 4 * k, 32'h300, 32'hB000 + k);
      tick();
    end
    we = 0;
    set_store(32'h700, 32'h300, 32'hB0FF); log_ready = 1;
    tick(); we = 0; log_ready = 0;
    chk("t5_no_ovf", log_overflow, 0);
    for (int k = 0; k < 16; k++) begin
      chk("t5_valid", log_valid, 1);
      chk("t5_data", log_data, (k < 15) ? 32'hB001 + k : 32'hB0FF);
      log_ready = 1; tick(); log_ready = 0;
    end
    chk("t5_count16", log_valid, 0);
    $display("T5 full push+pop done");

    // Random phase against the model
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        for (int i = 0; i < NW; i++) watch_addr[i*32 +: 32] = 32'h100 + $urandom_range(0, 63);
        watch_en = 4'($urandom);
      end
      we = ($urandom_range(0, 1) == 1);
      pc = $urandom; daddr = 32'h100 + $urandom_range(0, 63); wdata = $urandom;
      log_ready = ($urandom_range(0, 3) == 0);
      log_clr = ($urandom_range(0, 39) == 0);
      rst_n = (c != 400);
      tick();
      if (c % 100 == 0)
        $display("RND c=%0d cnt=%0d valid=%0b ovf=%0b", c, cycle_count, log_valid, log_overflow);
    end
    we = 0; log_clr = 0; log_ready = 0; rst_n = 1;

    // Test 6: halt store at cycle 40
    rst_n = 0; tick(); rst_n = 1;
    watch_addr[31:0] = 32'h60; watch_addr[95:64] = 32'h50; watch_en = 4'b0101;
    repeat (40) tick();
    chk("t6_cnt40", cycle_count, 40);
    set_store(32'h2000, 32'h50, 32'h0BAD_F00D);
    tick(); we = 0;
    chk("t6_halted", halted, 1);
    chk("t6_halt_cycle", halt_cycle, 40);
    chk("t6_hit", hit, 4'b0100);
    chk("t6_log_addr", log_addr, 32'h50);
    chk("t6_cnt41", cycle_count, 41);
    set_store(32'h2004, 32'h60, 32'h1); tick();
    set_store(32'h2008, 32'h50, 32'h2); tick(); we = 0;
    chk("t6_no_hit", hit, 0);
    chk("t6_wval_kept", watch_val[95:64], 32'h0BAD_F00D);
    log_ready = 1; tick(); log_ready = 0;
    chk("t6_no_push", log_valid, 0);
    repeat (3) tick();
    chk("t6_frozen", cycle_count, 41);
    $display("T6 halt done halt_cycle=%0d cycle_count=%0d", halt_cycle, cycle_count);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
